rx_temp_parser: RTL and testbench

RX_TEMP_PARSER -- requirements
Module: rx_temp_parser

---
 rtl/rx_temp_parser_pkg.sv | 66 ++++++
 rtl/rx_temp_parser_uart_rx.sv | 137 +++++++++++++
 rtl/rx_temp_parser.sv | 147 ++++++++++++++
 tb/tb_rx_temp_parser.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_temp_parser_pkg.sv
// -----------------------------------------------------------------------------
// rx_temp_parser_pkg
// Shared definitions for the UART temperature-message receiver: the expected
// characters of the "Temp: DD.D C\r\n" message, the parser and bit-receiver
// state enums, and small character helpers. The parser enum and character
// constants are also used by tx_parser.
// -----------------------------------------------------------------------------
package rx_temp_parser_pkg;

  // Message prefix, leftmost character in the most significant byte.
  localparam int          PREFIX_LEN = 6;
  localparam logic [47:0] PREFIX_STR = "Temp: ";
  localparam logic [2:0]  PREFIX_LAST_IDX = 3'(PREFIX_LEN - 1);

  localparam logic [7:0] CHAR_T     = "T";
  localparam logic [7:0] CHAR_DOT   = ".";
  localparam logic [7:0] CHAR_SPACE = " ";
  localparam logic [7:0] CHAR_C     = "C";
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_ZERO  = "0";
  localparam logic [7:0] CHAR_NINE  = "9";

  // Message grammar position. PS_PREFIX is qualified by a 0-5 prefix index.
  typedef enum logic [3:0] {
    PS_PREFIX,
    PS_TENS,
    PS_ONES,
    PS_DOT,
    PS_TENTHS,
    PS_SPACE,
    PS_CEL,
    PS_CR,
    PS_LF
  } parse_state_t;

  // UART 8N1 bit-level receiver states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Expected prefix character at a given prefix index (0 for out-of-range).
  function automatic logic [7:0] prefix_char(input logic [2:0] idx);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < PREFIX_LEN; i++) begin
      if (idx == 3'(i)) c = PREFIX_STR[8*(PREFIX_LEN-1-i) +: 8];
    end
    return c;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHAR_ZERO) && (c <= CHAR_NINE);
  endfunction

  // ASCII digit to its BCD nibble (byte minus '0').
  function automatic logic [3:0] ascii_to_bcd(input logic [7:0] c);
    logic [7:0] d;
    d = c - CHAR_ZERO;
    return d[3:0];
  endfunction

endpackage

// File: rtl/rx_temp_parser_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART 8N1 receiver, LSB first, idle-high line. The raw line is brought into
// the clock domain with a two-flop synchronizer; a start edge is confirmed at
// half a bit time (shorter low pulses are rejected as glitches), then each
// data bit and the stop bit are sampled at mid-bit.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_serial    raw UART line (asynchronous)
//   rx_byte      last received byte; valid while byte_valid is high
//   byte_valid   one-cycle strobe, stop bit sampled high
//   frame_error  one-cycle pulse, stop bit sampled low (no byte_valid)
// -----------------------------------------------------------------------------
module uart_rx
  import rx_temp_parser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int             CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_prev_q;
  logic          rx_sync;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          strobe_q, strobe_d;
  logic          ferr_q, ferr_d;

  assign rx_sync = sync_q[1];

  // Synchronizer and previous-sample flop reset to the idle (high) level so
  // reset release never looks like a start edge.
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values, which a synchronizer chain depends on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_serial};
      rx_prev_q <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_sync) state_d = RX_START;
      end

      // Confirm the start bit at its middle; a high line means a glitch.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Return to IDLE at the stop-bit middle so a back-to-back start edge
      // in the next half bit is caught.
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_sync) strobe_d = 1'b1;
          else         ferr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte     = shift_q;
  assign byte_valid  = strobe_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/rx_temp_parser.sv
// -----------------------------------------------------------------------------
// rx_temp_parser
// Receives UART bytes and parses messages of the form "Temp: DD.D C\r\n".
// Digits are collected in a shadow register; bcd_temp only updates when the
// whole message, including the final LF, has matched. Any grammar violation
// pulses parse_error and restarts matching (at prefix index 1 if the offending
// byte was 'T', so a new message starting there is not lost).
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_serial    UART 8N1 line, idle high, LSB first
//   bcd_temp     last accepted temperature {tens, ones, tenths} BCD
//   temp_valid   one-cycle pulse when bcd_temp updates
//   parse_error  one-cycle pulse on a message-grammar violation
//   frame_error  one-cycle pulse when a stop bit is sampled low
// -----------------------------------------------------------------------------
module rx_temp_parser
  import rx_temp_parser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_serial,
  output logic [11:0] bcd_temp,
  output logic        temp_valid,
  output logic        parse_error,
  output logic        frame_error
);

  logic [7:0]   rx_byte;
  logic         rx_strobe;
  logic         rx_ferr;

  parse_state_t state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [11:0]  shadow_q, shadow_d;
  logic [11:0]  bcd_q, bcd_d;
  logic         tv_q, tv_d;
  logic         pe_q, pe_d;
  logic         match;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .rx_byte     (rx_byte),
    .byte_valid  (rx_strobe),
    .frame_error (rx_ferr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PS_PREFIX;
      idx_q    <= '0;
      shadow_q <= '0;
      bcd_q    <= '0;
      tv_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      bcd_q    <= bcd_d;
      tv_q     <= tv_d;
      pe_q     <= pe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    bcd_d    = bcd_q;
    tv_d     = 1'b0;
    pe_d     = 1'b0;
    match    = 1'b0;

    if (rx_ferr) begin
      // A corrupted byte breaks the message; only report it if one was open.
      pe_d    = (state_q != PS_PREFIX) || (idx_q != 3'd0);
      state_d = PS_PREFIX;
      idx_d   = '0;
    end else if (rx_strobe) begin
      unique case (state_q)
        PS_PREFIX:                     match = (rx_byte == prefix_char(idx_q));
        PS_TENS, PS_ONES, PS_TENTHS:   match = is_digit(rx_byte);
        PS_DOT:                        match = (rx_byte == CHAR_DOT);
        PS_SPACE:                      match = (rx_byte == CHAR_SPACE);
        PS_CEL:                        match = (rx_byte == CHAR_C);
        PS_CR:                         match = (rx_byte == CHAR_CR);
        PS_LF:                         match = (rx_byte == CHAR_LF);
        default:                       match = 1'b0;
      endcase

      if (match) begin
        unique case (state_q)
          PS_PREFIX: begin
            if (idx_q == PREFIX_LAST_IDX) begin
              idx_d   = '0;
              state_d = PS_TENS;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
          PS_TENS: begin
            shadow_d[11:8] = ascii_to_bcd(rx_byte);
            state_d        = PS_ONES;
          end
          PS_ONES: begin
            shadow_d[7:4] = ascii_to_bcd(rx_byte);
            state_d       = PS_DOT;
          end
          PS_DOT:    state_d = PS_TENTHS;
          PS_TENTHS: begin
            shadow_d[3:0] = ascii_to_bcd(rx_byte);
            state_d       = PS_SPACE;
          end
          PS_SPACE:  state_d = PS_CEL;
          PS_CEL:    state_d = PS_CR;
          PS_CR:     state_d = PS_LF;
          PS_LF: begin
            bcd_d   = shadow_q;
            tv_d    = 1'b1;
            state_d = PS_PREFIX;
          end
          default:   state_d = PS_PREFIX;
        endcase
      end else if (!((state_q == PS_PREFIX) && (idx_q == 3'd0))) begin
        // Hunting for the first 'T' is silent; anywhere else a mismatch is an
        // error, and a 'T' is treated as the start of the next message.
        pe_d    = 1'b1;
        state_d = PS_PREFIX;
        idx_d   = (rx_byte == CHAR_T) ? 3'd1 : 3'd0;
      end
    end
  end

  assign bcd_temp    = bcd_q;
  assign temp_valid  = tv_q;
  assign parse_error = pe_q;
  assign frame_error = rx_ferr;

endmodule

// File: tb/tb_rx_temp_parser.sv
// -----------------------------------------------------------------------------
// tb_rx_temp_parser
// Self-checking bench for rx_temp_parser with CLKS_PER_BIT = 8. Directed
// scenarios use the expected values of the message examples; a randomized
// stream of messages, junk and corrupted bytes is checked against a template
// matching model of the message grammar.
// -----------------------------------------------------------------------------
module tb_rx_temp_parser;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_serial;
  logic [11:0] bcd_temp;
  logic        temp_valid;
  logic        parse_error;
  logic        frame_error;

  rx_temp_parser #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .bcd_temp    (bcd_temp),
    .temp_valid  (temp_valid),
    .parse_error (parse_error),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- output monitor (samples on falling edge) ----------------
  int          obs_tv = 0, obs_pe = 0, obs_fe = 0, obs_double = 0;
  logic [11:0] obs_q[$];
  logic        prev_tv = 1'b0, prev_pe = 1'b0, prev_fe = 1'b0;

  always @(negedge clk) begin
    if (temp_valid) begin
      obs_tv++;
      obs_q.push_back(bcd_temp);
    end
    if (parse_error) obs_pe++;
    if (frame_error) obs_fe++;
    if ((temp_valid && prev_tv) || (parse_error && prev_pe) || (frame_error && prev_fe))
      obs_double++;
    prev_tv = temp_valid;
    prev_pe = parse_error;
    prev_fe = frame_error;
  end

  task automatic clear_obs();
    @(negedge clk);
    obs_tv = 0; obs_pe = 0; obs_fe = 0; obs_double = 0;
    obs_q.delete();
  endtask

  // ---------------- reference model: template matching ----------------
  string       tmpl = "Temp: ##.# C\r\n";
  int          m_pos = 0;
  int          m_dig[3];
  int          m_dn = 0;
  int          exp_pe = 0, exp_fe = 0;
  logic [11:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b, input bit fe);
    logic [7:0] want;
    bit         ok;
    if (fe) begin
      exp_fe++;
      if (m_pos != 0) exp_pe++;
      m_pos = 0;
      m_dn  = 0;
      return;
    end
    want = tmpl[m_pos];
    if (want == "#") ok = (b >= "0") && (b <= "9");
    else             ok = (b == want);
    if (ok) begin
      if (want == "#") begin
        m_dig[m_dn] = int'(b) - 48;
        m_dn++;
      end
      m_pos++;
      if (m_pos == tmpl.len()) begin
        exp_q.push_back({m_dig[0][3:0], m_dig[1][3:0], m_dig[2][3:0]});
        m_pos = 0;
        m_dn  = 0;
      end
    end else begin
      if (m_pos != 0) exp_pe++;
      m_pos = (b == "T") ? 1 : 0;
      m_dn  = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx_serial = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      wait_cycles(CPB);
    end
    rx_serial = bad_stop ? 1'b0 : 1'b1;
    wait_cycles(CPB);
    rx_serial = 1'b1;
    if (bad_stop) wait_cycles(2 * CPB);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic settle();
    wait_cycles(4 * CPB);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    n_checks++;
    if (bcd_temp !== 12'h000) $display("FAIL reset_bcd: got %h want 000", bcd_temp);
    else n_pass++;
    n_checks++;
    if ({temp_valid, parse_error, frame_error} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {temp_valid, parse_error, frame_error});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    wait_cycles(30);
    n_checks++;
    if (obs_tv + obs_pe + obs_fe !== 0)
      $display("FAIL reset_release_pulses: got %0d want 0", obs_tv + obs_pe + obs_fe);
    else n_pass++;
  endtask

  task automatic test_basic();
    clear_obs();
    send_str("Temp: 23.7 C\r\n");
    settle();
    n_checks++;
    if (bcd_temp !== 12'h237) $display("FAIL basic_bcd: got %h want 237", bcd_temp);
    else n_pass++;
    n_checks++;
    if (obs_tv !== 1) $display("FAIL basic_valid_count: got %0d want 1", obs_tv);
    else n_pass++;
    n_checks++;
    if (obs_pe + obs_fe !== 0) $display("FAIL basic_errors: got %0d want 0", obs_pe + obs_fe);
    else n_pass++;
  endtask

  task automatic test_parse_error();
    clear_obs();
    send_str("Temp: 2x.7 C\r\n");
    settle();
    n_checks++;
    if (obs_pe !== 1) $display("FAIL perr_count: got %0d want 1", obs_pe);
    else n_pass++;
    n_checks++;
    if (obs_tv !== 0 || bcd_temp !== 12'h237)
      $display("FAIL perr_hold: valid %0d bcd %h want 0 237", obs_tv, bcd_temp);
    else n_pass++;
    send_str("Temp: 05.0 C\r\n");
    settle();
    n_checks++;
    if (bcd_temp !== 12'h050 || obs_tv !== 1)
      $display("FAIL perr_recover: bcd %h valid %0d want 050 1", bcd_temp, obs_tv);
    else n_pass++;
    n_checks++;
    if (obs_pe !== 1) $display("FAIL perr_recover_errors: got %0d want 1", obs_pe);
    else n_pass++;
  endtask

  task automatic test_resync();
    clear_obs();
    send_str("A");
    settle();
    n_checks++;
    if (obs_pe !== 0) $display("FAIL resync_leading_junk: got %0d want 0", obs_pe);
    else n_pass++;
    send_str("TTemp: 19.4 C\r\n");
    settle();
    n_checks++;
    if (obs_pe !== 1) $display("FAIL resync_perr: got %0d want 1", obs_pe);
    else n_pass++;
    n_checks++;
    if (bcd_temp !== 12'h194 || obs_tv !== 1)
      $display("FAIL resync_bcd: bcd %h valid %0d want 194 1", bcd_temp, obs_tv);
    else n_pass++;
  endtask

  task automatic test_frame_error();
    clear_obs();
    send_str("Temp: 1");
    send_byte("2", 1'b1);
    send_str(".3 C\r\n");
    settle();
    n_checks++;
    if (obs_fe !== 1) $display("FAIL ferr_count: got %0d want 1", obs_fe);
    else n_pass++;
    n_checks++;
    if (obs_pe !== 1) $display("FAIL ferr_perr: got %0d want 1", obs_pe);
    else n_pass++;
    n_checks++;
    if (obs_tv !== 0 || bcd_temp !== 12'h194)
      $display("FAIL ferr_hold: valid %0d bcd %h want 0 194", obs_tv, bcd_temp);
    else n_pass++;
  endtask

  // Glitch placed mid-message: an accepted glitch would be a 0xFF byte and
  // trip parse_error.
  task automatic test_glitch();
    clear_obs();
    send_str("Temp");
    wait_cycles(CPB);
    rx_serial = 1'b0;
    wait_cycles(3);
    rx_serial = 1'b1;
    wait_cycles(3 * CPB);
    n_checks++;
    if (obs_pe + obs_fe !== 0) $display("FAIL glitch_errors: got %0d want 0", obs_pe + obs_fe);
    else n_pass++;
    send_str(": 42.1 C\r\n");
    settle();
    n_checks++;
    if (bcd_temp !== 12'h421 || obs_tv !== 1 || obs_pe !== 0)
      $display("FAIL glitch_decode: bcd %h valid %0d perr %0d want 421 1 0", bcd_temp, obs_tv, obs_pe);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] c;
    c = "8";
    send_str("Temp: 8");
    rx_serial = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_serial = c[i];
      wait_cycles(CPB);
    end
    rst_n     = 1'b0;
    rx_serial = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    n_checks++;
    if ({bcd_temp, temp_valid, parse_error, frame_error} !== 15'h0)
      $display("FAIL midreset_outputs: bcd %h tv %b pe %b fe %b want all 0",
               bcd_temp, temp_valid, parse_error, frame_error);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_obs();
    wait_cycles(2 * CPB);
    n_checks++;
    if (obs_tv + obs_pe + obs_fe !== 0)
      $display("FAIL midreset_release: got %0d pulses want 0", obs_tv + obs_pe + obs_fe);
    else n_pass++;
    send_str("Temp: 88.8 C\r\n");
    settle();
    n_checks++;
    if (bcd_temp !== 12'h888 || obs_tv !== 1 || obs_pe !== 0)
      $display("FAIL midreset_decode: bcd %h valid %0d perr %0d want 888 1 0", bcd_temp, obs_tv, obs_pe);
    else n_pass++;
  endtask

  task automatic test_random();
    string       alph = "Temp: 0123456789.C\r\nxT";
    string       s;
    logic [7:0]  msg[14];
    logic [11:0] last_exp;
    int          p, mode, nj;
    clear_obs();
    m_pos = 0; m_dn = 0; exp_pe = 0; exp_fe = 0;
    exp_q.delete();
    last_exp = 12'h888;
    for (int m = 0; m < 12; m++) begin
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        logic [7:0] jb;
        jb = alph[$urandom_range(0, alph.len() - 1)];
        model_byte(jb, 1'b0);
        send_byte(jb, 1'b0);
      end
      s = $sformatf("Temp: %0d%0d.%0d C\r\n", $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9));
      for (int i = 0; i < 14; i++) msg[i] = s[i];
      mode = $urandom_range(0, 5);
      p    = $urandom_range(0, 13);
      if (mode < 2) msg[p] = alph[$urandom_range(0, alph.len() - 1)];
      for (int i = 0; i < 14; i++) begin
        bit fe;
        fe = (mode == 2) && (i == p);
        model_byte(msg[i], fe);
        send_byte(msg[i], fe);
        if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, CPB));
      end
    end
    settle();
    if (exp_q.size() > 0) last_exp = exp_q[exp_q.size() - 1];
    n_checks++;
    if (obs_tv !== exp_q.size()) $display("FAIL rand_valid_count: got %0d want %0d", obs_tv, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rand_bcd_%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_pe !== exp_pe) $display("FAIL rand_perr_count: got %0d want %0d", obs_pe, exp_pe);
    else n_pass++;
    n_checks++;
    if (obs_fe !== exp_fe) $display("FAIL rand_ferr_count: got %0d want %0d", obs_fe, exp_fe);
    else n_pass++;
    n_checks++;
    if (bcd_temp !== last_exp) $display("FAIL rand_final_bcd: got %h want %h", bcd_temp, last_exp);
    else n_pass++;
    n_checks++;
    if (obs_double !== 0) $display("FAIL rand_pulse_width: got %0d long pulses want 0", obs_double);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parse_error();
    test_resync();
    test_frame_error();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
